mlp_scheduler: RTL and testbench
================================

# mlp_scheduler

Time-multiplexes the single `mlp_OX` instance between the training controller's sample stream and user inference requests from the submit path. It owns the NN input port (`x`, `learn`, `is_O`) and sequences each access as a fixed-length window. It captures inference results into hold registers with a display-hold timer. It sits between `train_controller`/`input_manager` and `mlp_OX`, replacing the combinational training/inference mux in `top`.

## Interface
- `XW`, 16: NN input vector width.
- `NN_LAT`, 4: cycles from `nn_x` stable until `nn_y`/`nn_prob` are valid; must be ≥1.
- `HOLD_CYC`, 150000000: cycles `res_valid` stays high after a capture (3 s at 50 MHz); must be ≥1.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, asynchronous, active-low.
- `train_req`  in  1  level request; `train_x`/`train_is_O` stable while high.
- `train_x`  in  XW  training sample.
- `train_is_O`  in  1  training label.
- `train_done`  out  1  one-cycle pulse: sample's learn cycle issued.
- `inf_req`  in  1  one-cycle pulse (submit rising edge); `inf_x` sampled the same cycle.
- `inf_x`  in  XW  inference vector.
- `inf_drop`  out  1  one-cycle pulse: a pending inference was overwritten.
- `nn_x`  out  XW  to `mlp_OX.x`.
- `nn_learn`  out  1  to `mlp_OX.learn`.
- `nn_is_O`  out  1  to `mlp_OX.is_O`.
- `nn_y`  in  1  NN decision.
- `nn_prob`  in  7  NN O-probability, 0–100.
- `res_valid`  out  1  inference result hold active.
- `res_y`  out  1  captured decision.
- `res_prob`  out  7  captured probability.
- `busy`  out  1  state ≠ IDLE.
- `train_cnt`  out  16  completed training samples, saturating at 65535.

## Operation
- Reset: all outputs 0, state IDLE, pending cleared, window counter 0, hold timer 0. Reset mid-window aborts without issuing `nn_learn`.
- Pending inference buffer, one deep:
  - `inf_req` latches `inf_x` and sets `pend`.
  - If `pend` is already set (or is being consumed at the same edge), the new vector overwrites the buffer and `inf_drop` pulses. After a consume collision, `pend` stays set with the new vector.
- FSM states IDLE, TRAIN, INFER.
- IDLE arbitration:
  - Default priority: `pend` over `train_req`.
  - Exception: in the IDLE cycle after an INFER window, `train_req` wins if high, which prevents training starvation.
  - `train_req` is ignored in the IDLE cycle immediately after `train_done`.
- Grant edge:
  - `nn_x` is loaded from the chosen operand.
  - `nn_is_O` is loaded with `train_is_O` for TRAIN, 0 for INFER.
  - The window counter is cleared; for INFER, `pend` is cleared.
- Window: counter runs 0..NN_LAT, then the FSM returns to IDLE.
- TRAIN, cnt==NN_LAT:
  - `nn_learn`=1 for that cycle only.
  - `train_done` pulses; `train_cnt` increments (saturating).
- INFER, cnt==NN_LAT:
  - `nn_y`/`nn_prob` are registered into `res_y`/`res_prob`.
  - `res_valid` is set and the hold timer is loaded with HOLD_CYC.
- `nn_x` holds its last value in IDLE. `nn_is_O` and `nn_learn` are 0 outside TRAIN.
- Hold timer:
  - Decrements while nonzero; `res_valid` drops when it reaches 0.
  - A new capture during a hold reloads the timer.
  - `res_y`/`res_prob` persist after `res_valid` falls until the next capture.
  - Training runs freely during a hold and does not alter the result registers.

## Timing
- All outputs are registered.
- Inference latency: `inf_req` at cycle t (IDLE, no pending, no train priority):
  - `pend` is set at edge t.
  - Grant at edge t+1.
  - cnt=0 at t+2; capture at the end of t+2+NN_LAT.
  - `res_valid` is high from t+3+NN_LAT, i.e. NN_LAT+3 cycles after the request.
  - `res_valid` stays high for exactly HOLD_CYC cycles.
- Training: `train_req` high at cycle t in IDLE gives grant at edge t and `train_done`/`nn_learn` at cycle t+1+NN_LAT.
- Continuous `train_req`: the requester updates the sample at the `train_done` edge. Sustained period is NN_LAT+3 cycles per sample.
- Simultaneous `inf_req` and the first `train_req` in IDLE, `pend` clear: TRAIN is granted that edge, because `pend` is not yet set. INFER follows that window.
- `busy` rises the cycle after the grant edge and falls the cycle after cnt==NN_LAT.

## Test plan
- Reset then `inf_req` with `inf_x`=16'h9009, model `nn_y`=1, `nn_prob`=87: `nn_x`=16'h9009 at t+2; `res_valid` rises at t+7 (NN_LAT=4) with `res_y`=1, `res_prob`=87; it falls after HOLD_CYC (use 20 in the bench).
- `train_req` held high for 3 samples: exactly 3 `nn_learn` pulses, each coincident with `train_done`; pulses spaced 7 cycles apart; `train_cnt`=3; `nn_is_O` matches each label across its window.
- `inf_req` mid-TRAIN, then a second `inf_req` before the grant: `inf_drop` pulses once; the INFER window uses the second vector; the training window is not truncated.
- After an INFER completes with `train_req` high and a new `inf_req` pending: TRAIN is granted first, then INFER.
- `rst` asserted at cnt=2 of TRAIN: all outputs are 0 immediately; no `nn_learn` pulse; `train_cnt`=0 after release.
- New capture at hold timer=5: `res_valid` stays high; the timer reloads to HOLD_CYC; `res_prob` updates.

Source files
------------

// File: rtl/mlp_sched_if.sv
// Port bundle between mlp_scheduler and its requesters / the mlp_OX instance.
// master is the environment side (requesters + NN), slave is the scheduler.
interface mlp_sched_if #(
  parameter int XW = 16
);
  logic          train_req;
  logic [XW-1:0] train_x;
  logic          train_is_O;
  logic          train_done;
  logic          inf_req;
  logic [XW-1:0] inf_x;
  logic          inf_drop;
  logic [XW-1:0] nn_x;
  logic          nn_learn;
  logic          nn_is_O;
  logic          nn_y;
  logic [6:0]    nn_prob;
  logic          res_valid;
  logic          res_y;
  logic [6:0]    res_prob;
  logic          busy;
  logic [15:0]   train_cnt;

  modport master (
    output train_req, train_x, train_is_O, inf_req, inf_x, nn_y, nn_prob,
    input  train_done, inf_drop, nn_x, nn_learn, nn_is_O,
           res_valid, res_y, res_prob, busy, train_cnt
  );

  modport slave (
    input  train_req, train_x, train_is_O, inf_req, inf_x, nn_y, nn_prob,
    output train_done, inf_drop, nn_x, nn_learn, nn_is_O,
           res_valid, res_y, res_prob, busy, train_cnt
  );
endinterface

// File: rtl/mlp_scheduler.sv
// Time-multiplexes one mlp_OX between training samples and user inferences,
// each access a fixed NN_LAT+1 cycle window; inference results held on a timer.
module mlp_scheduler #(
  parameter int XW       = 16,
  parameter int NN_LAT   = 4,
  parameter int HOLD_CYC = 150000000
) (
  input  logic       clk,
  input  logic       rst,
  mlp_sched_if.slave bus
);
  localparam int CW = $clog2(NN_LAT + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, TRAIN = 2'd1, INFER = 2'd2} st_e;

  st_e           st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [XW-1:0] buf_q, buf_d, nn_x_q, nn_x_d;
  logic          pend_q, pend_d, inf_drop_q, inf_drop_d;
  logic          nn_learn_q, nn_learn_d, nn_is_o_q, nn_is_o_d;
  logic          train_done_q, train_done_d;
  logic          after_train_q, after_train_d, after_inf_q, after_inf_d;
  logic          res_valid_q, res_valid_d, res_y_q, res_y_d;
  logic [6:0]    res_prob_q, res_prob_d;
  logic          busy_q, busy_d;
  logic [15:0]   train_cnt_q, train_cnt_d;
  logic          gnt_train, gnt_inf, win_end, learn_next;

  // Training wins right after an inference window so a stream of submits
  // cannot starve it; it sits out the idle cycle right after its own done.
  assign gnt_train  = (st_q == IDLE) && bus.train_req && !after_train_q &&
                      (after_inf_q || !pend_q);
  assign gnt_inf    = (st_q == IDLE) && pend_q && !gnt_train;
  assign win_end    = (st_q != IDLE) && (cnt_q == CW'(NN_LAT));
  assign learn_next = (st_q == TRAIN) && (cnt_q == CW'(NN_LAT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_q <= IDLE;
    else      st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:         if (gnt_train) st_d = TRAIN;
                    else if (gnt_inf) st_d = INFER;
      TRAIN, INFER: if (win_end) st_d = IDLE;
      default:      st_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = (st_q == IDLE || win_end) ? '0 : cnt_q + 1'b1;
    nn_x_d       = nn_x_q;
    nn_is_o_d    = nn_is_o_q;
    if (gnt_train) begin
      nn_x_d    = bus.train_x;
      nn_is_o_d = bus.train_is_O;
    end else if (gnt_inf) begin
      nn_x_d    = buf_q;
      nn_is_o_d = 1'b0;
    end else if (win_end) begin
      nn_is_o_d = 1'b0;
    end
    // Registered outputs: assert one cycle early so they line up with cnt==NN_LAT.
    nn_learn_d    = learn_next;
    train_done_d  = learn_next;
    train_cnt_d   = (learn_next && train_cnt_q != 16'hFFFF) ? train_cnt_q + 16'd1 : train_cnt_q;
    after_train_d = win_end && (st_q == TRAIN);
    after_inf_d   = win_end && (st_q == INFER);

    // A request landing on the consume edge still counts as an overwrite.
    buf_d      = buf_q;
    pend_d     = pend_q && !gnt_inf;
    inf_drop_d = bus.inf_req && pend_q;
    if (bus.inf_req) begin
      buf_d  = bus.inf_x;
      pend_d = 1'b1;
    end

    res_y_d     = res_y_q;
    res_prob_d  = res_prob_q;
    hold_d      = hold_q;
    res_valid_d = res_valid_q;
    if (after_inf_d) begin
      res_y_d     = bus.nn_y;
      res_prob_d  = bus.nn_prob;
      hold_d      = HW'(HOLD_CYC);
      res_valid_d = 1'b1;
    end else if (hold_q != '0) begin
      hold_d      = hold_q - 1'b1;
      res_valid_d = (hold_q != HW'(1));
    end
    busy_d = (st_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q         <= '0;
      hold_q        <= '0;
      buf_q         <= '0;
      nn_x_q        <= '0;
      pend_q        <= 1'b0;
      inf_drop_q    <= 1'b0;
      nn_learn_q    <= 1'b0;
      nn_is_o_q     <= 1'b0;
      train_done_q  <= 1'b0;
      after_train_q <= 1'b0;
      after_inf_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_y_q       <= 1'b0;
      res_prob_q    <= '0;
      busy_q        <= 1'b0;
      train_cnt_q   <= '0;
    end else begin
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      buf_q         <= buf_d;
      nn_x_q        <= nn_x_d;
      pend_q        <= pend_d;
      inf_drop_q    <= inf_drop_d;
      nn_learn_q    <= nn_learn_d;
      nn_is_o_q     <= nn_is_o_d;
      train_done_q  <= train_done_d;
      after_train_q <= after_train_d;
      after_inf_q   <= after_inf_d;
      res_valid_q   <= res_valid_d;
      res_y_q       <= res_y_d;
      res_prob_q    <= res_prob_d;
      busy_q        <= busy_d;
      train_cnt_q   <= train_cnt_d;
    end
  end

  assign bus.nn_x       = nn_x_q;
  assign bus.nn_learn   = nn_learn_q;
  assign bus.nn_is_O    = nn_is_o_q;
  assign bus.train_done = train_done_q;
  assign bus.inf_drop   = inf_drop_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_y      = res_y_q;
  assign bus.res_prob   = res_prob_q;
  assign bus.busy       = busy_q;
  assign bus.train_cnt  = train_cnt_q;
endmodule

// File: tb/tb_mlp_scheduler.sv
// Directed bench for mlp_scheduler with NN_LAT=4, HOLD_CYC=20; the NN is
// modelled by driving nn_y/nn_prob constants around each capture.
module tb_mlp_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  mlp_sched_if #(.XW(16)) bus ();
  mlp_scheduler #(.XW(16), .NN_LAT(4), .HOLD_CYC(20)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n, nlearn, bad, ndone, c;
    int done_c [3];
    logic [15:0] xs [3];
    logic        lb [3];
    logic [15:0] curx;
    logic        lbl;

    bus.train_req = 0; bus.train_x = '0; bus.train_is_O = 0;
    bus.inf_req = 0; bus.inf_x = '0; bus.nn_y = 0; bus.nn_prob = '0;
    step(2);
    chk("rst_busy", bus.busy, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_nn_x", bus.nn_x, 0);
    chk("rst_train_cnt", bus.train_cnt, 0);
    chk("rst_learn", bus.nn_learn, 0);
    rst = 1;
    step(2);

    // Single inference: request at cycle t
    bus.inf_req = 1; bus.inf_x = 16'h9009; bus.nn_y = 1; bus.nn_prob = 7'd87;
    step(1);
    bus.inf_req = 0;
    chk("inf_t1_busy", bus.busy, 0);
    step(1);
    chk("inf_t2_nn_x", bus.nn_x, 16'h9009);
    chk("inf_t2_busy", bus.busy, 1);
    chk("inf_t2_is_O", bus.nn_is_O, 0);
    step(4);
    chk("inf_t6_res_valid", bus.res_valid, 0);
    step(1);
    chk("inf_t7_res_valid", bus.res_valid, 1);
    chk("inf_t7_res_y", bus.res_y, 1);
    chk("inf_t7_res_prob", bus.res_prob, 87);
    chk("inf_t7_busy", bus.busy, 0);
    n = 0;
    while (bus.res_valid && n < 100) begin n++; step(1); end
    chk("inf_hold_len", n, 20);
    chk("inf_prob_persist", bus.res_prob, 87);

    // Three back-to-back training samples
    xs[0] = 16'hA1A1; xs[1] = 16'hB2B2; xs[2] = 16'hC3C3;
    lb[0] = 1'b1;     lb[1] = 1'b0;     lb[2] = 1'b1;
    curx = xs[0]; lbl = lb[0];
    bus.train_x = curx; bus.train_is_O = lbl; bus.train_req = 1;
    c = 0; ndone = 0; nlearn = 0; bad = 0;
    while (ndone < 3 && c < 60) begin
      step(1); c++;
      if (bus.nn_learn !== bus.train_done) bad++;
      if (bus.nn_learn) nlearn++;
      if (bus.busy && (bus.nn_is_O !== lbl || bus.nn_x !== curx)) bad++;
      if (!bus.busy && bus.nn_is_O !== 1'b0) bad++;
      if (bus.train_done) begin
        done_c[ndone] = c;
        ndone++;
        if (ndone < 3) begin
          curx = xs[ndone]; lbl = lb[ndone];
          bus.train_x = curx; bus.train_is_O = lbl;
        end else begin
          bus.train_req = 0;
        end
      end
    end
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (bus.nn_learn) nlearn++;
    end
    chk("trn_ndone", ndone, 3);
    chk("trn_done0", done_c[0], 5);
    chk("trn_done1", done_c[1], 12);
    chk("trn_done2", done_c[2], 19);
    chk("trn_nlearn", nlearn, 3);
    chk("trn_align", bad, 0);
    chk("trn_cnt3", bus.train_cnt, 3);

    // Inference overwrite during TRAIN, then train priority after INFER
    bus.nn_y = 0; bus.nn_prob = 7'd33;
    bus.train_req = 1; bus.train_x = 16'h1111; bus.train_is_O = 0;
    step(2);
    bus.inf_req = 1; bus.inf_x = 16'hAAAA;
    step(1);
    chk("ovw_no_drop_first", bus.inf_drop, 0);
    bus.inf_x = 16'hBBBB;
    step(1);
    bus.inf_req = 0;
    chk("ovw_drop", bus.inf_drop, 1);
    step(1);
    chk("ovw_train_done", bus.train_done, 1);
    chk("ovw_learn", bus.nn_learn, 1);
    chk("ovw_drop_once", bus.inf_drop, 0);
    bus.train_req = 0;
    step(1);
    chk("ovw_idle", bus.busy, 0);
    step(1);
    chk("ovw_inf_x", bus.nn_x, 16'hBBBB);
    chk("ovw_inf_busy", bus.busy, 1);
    bus.train_req = 1; bus.train_x = 16'h2222; bus.train_is_O = 1;
    step(1);
    bus.inf_req = 1; bus.inf_x = 16'hCCCC;
    step(1);
    bus.inf_req = 0;
    chk("pri_no_drop", bus.inf_drop, 0);
    step(3);
    chk("ovw_res_valid", bus.res_valid, 1);
    chk("ovw_res_prob", bus.res_prob, 33);
    chk("ovw_train_cnt", bus.train_cnt, 4);
    chk("pri_idle", bus.busy, 0);
    bus.nn_y = 1; bus.nn_prob = 7'd50;
    step(1);
    chk("pri_train_x", bus.nn_x, 16'h2222);
    chk("pri_train_is_O", bus.nn_is_O, 1);
    step(4);
    chk("pri_train_done", bus.train_done, 1);
    bus.train_req = 0;
    step(1);
    chk("pri_gap_busy", bus.busy, 0);
    chk("pri_gap_is_O", bus.nn_is_O, 0);
    step(1);
    chk("pri_inf_x", bus.nn_x, 16'hCCCC);
    chk("pri_inf_is_O", bus.nn_is_O, 0);
    chk("pri_inf_busy", bus.busy, 1);
    step(5);
    chk("pri_res_prob", bus.res_prob, 50);
    chk("pri_res_y", bus.res_y, 1);
    chk("pri_train_cnt", bus.train_cnt, 5);
    n = 0;
    while (bus.res_valid && n < 100) begin n++; step(1); end
    chk("pri_hold_len", n, 20);

    // Recapture when the hold timer is at 5
    bus.inf_req = 1; bus.inf_x = 16'h5555; bus.nn_y = 0; bus.nn_prob = 7'd10;
    step(1);
    bus.inf_req = 0;
    step(6);
    chk("rcp_first_valid", bus.res_valid, 1);
    chk("rcp_first_prob", bus.res_prob, 10);
    step(9);
    bus.inf_req = 1; bus.inf_x = 16'h7777; bus.nn_prob = 7'd99;
    step(1);
    bus.inf_req = 0;
    step(5);
    chk("rcp_pre_valid", bus.res_valid, 1);
    chk("rcp_pre_prob", bus.res_prob, 10);
    step(1);
    chk("rcp_new_prob", bus.res_prob, 99);
    n = 0;
    while (bus.res_valid && n < 100) begin n++; step(1); end
    chk("rcp_reload_len", n, 20);

    // Asynchronous reset at cnt=2 of a TRAIN window
    bus.train_req = 1; bus.train_x = 16'h3C3C; bus.train_is_O = 1;
    step(3);
    chk("ar_pre_busy", bus.busy, 1);
    chk("ar_pre_is_O", bus.nn_is_O, 1);
    rst = 0;
    #1;
    chk("ar_busy", bus.busy, 0);
    chk("ar_nn_x", bus.nn_x, 0);
    chk("ar_is_O", bus.nn_is_O, 0);
    chk("ar_train_cnt", bus.train_cnt, 0);
    chk("ar_res_prob", bus.res_prob, 0);
    nlearn = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (bus.nn_learn || bus.train_done) nlearn++;
    end
    rst = 1; bus.train_req = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (bus.nn_learn || bus.train_done) nlearn++;
    end
    chk("ar_no_learn", nlearn, 0);
    chk("ar_post_cnt", bus.train_cnt, 0);
    chk("ar_post_busy", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
